game_frame_tx: RTL and testbench
================================

# game_frame_tx

Transmitter for the game's host-facing readout link. It captures a snapshot of game state and sends it to the off-chip host one 5-bit word at a time, using a tagged, four-phase valid/ack handshake. It sits next to the controls, target generator and trajectory calculator in the top level and replaces the ad-hoc select-driven output mux. A round frame sends target X, then target Y, then cannon position, and only then pulses `game_go`. A result frame reports the shot outcome.

## Interface
- `TIMEOUT`, default 255: cycles to wait for any single ack edge before the frame is aborted; range 1..255, counter is 8 bits.
- `clk` input 1: system clock.
- `rst_n` input 1: synchronous, active-low reset.
- `start_new_game` input 1: request for a round frame, sampled each cycle.
- `result_valid` input 1: request for a result frame, sampled each cycle.
- `hit` input 1: shot outcome.
- `target_x` input 5: target X.
- `target_y` input 5: target Y.
- `x_pos` input 5: cannon position.
- `aim_pos` input 3: aim index.
- `tc_pos` input 5: final trajectory X.
- `host_ack` input 1: host acknowledge, asynchronous, synchronized internally.
- `tx_data` output 5: current word.
- `tx_tag` output 3: word type. 0 idle, 1 TGT_X, 2 TGT_Y, 3 CANNON, 4 STATUS, 5 TC_POS.
- `tx_valid` output 1: word is valid.
- `game_go` output 1: one-cycle pulse when a round frame completes.
- `busy` output 1: a frame is in progress.
- `timeout_err` output 1: sticky abort flag.

## Operation
- Reset: every output is 0, state is IDLE, all pending flags and snapshot registers are 0, ack synchronizer flops are 0.
- `host_ack` passes through a 2-flop synchronizer; `ack_s` is the second flop.
- Requests:
  - Any cycle with `start_new_game`=1 sets `pend_start`; any cycle with `result_valid`=1 sets `pend_result`.
  - Repeated requests collapse into one.
  - A flag clears when its frame is launched.
- IDLE arbitration: `pend_start` (or a live `start_new_game`) has priority over result. Both in the same cycle: round frame first, result stays pending.
- Launch (IDLE→PRESENT edge):
  - Snapshot all data inputs into frame registers; data is sampled at launch, not at request time.
  - Word index goes to 0, `busy`=1, `timeout_err` clears.
- Round frame words: TGT_X=`target_x`, TGT_Y=`target_y`, CANNON=`x_pos`.
- Result frame words: STATUS={`aim_pos`,1'b0,`hit`}, TC_POS=`tc_pos`.
- States:
  - IDLE: `tx_valid`=0, `tx_tag`=0, `tx_data`=0.
  - PRESENT: `tx_valid`=1 with the current word and tag held stable. On `ack_s`=1 go to RELEASE.
  - RELEASE: `tx_valid`=0, data and tag held. On `ack_s`=0, go to PRESENT with the next word if one remains, else DONE.
  - DONE: one cycle. `game_go`=1 only for a round frame. `busy` drops on exit; then IDLE.
- Timeout:
  - An 8-bit counter clears on entry to PRESENT or RELEASE and increments every cycle spent there.
  - When it reaches `TIMEOUT`: go to IDLE, `tx_valid`=0, `timeout_err`=1, no `game_go`, frame discarded.
  - Pending flags are kept.
- Reset mid-frame: immediate return to reset values; pending requests are lost.

## Timing
- Request sampled at edge N in IDLE → `tx_valid`=1 with word 0 from edge N+1.
- Ack rises before edge M → `ack_s`=1 after edge M+1 → `tx_valid`=0 after edge M+2.
- Ack falls before edge K → next word valid after edge K+2.
- DONE lasts one cycle; a pending frame launches on the cycle after the return to IDLE.
- Minimum round frame with an instant host: 3×(2+2+2) handshake cycles plus launch and DONE.

## Test plan
- Round frame with `target_x`=7, `target_y`=19, `x_pos`=3, host acking after 3 cycles:
  - sequence (tag,data) = (1,7), (2,19), (3,3);
  - `tx_valid` low between words;
  - single `game_go` pulse after the final release; `busy` then 0.
- Result frame with `hit`=1, `aim_pos`=5, `tc_pos`=12:
  - words (4,5'b10101), (5,12);
  - no `game_go`.
- `start_new_game` and `result_valid` together in IDLE:
  - full round frame, then result frame launches automatically;
  - data changed mid round appears in the result frame.
- Snapshot: change `target_x` after launch; transmitted TGT_X keeps the launch value.
- Timeout with `TIMEOUT`=10 and the host never acking:
  - `tx_valid` drops after 10 cycles in PRESENT;
  - `timeout_err`=1, no `game_go`;
  - next request clears `timeout_err` and completes normally.
- `rst_n` low during RELEASE of word 2: all outputs 0 on the next cycle; no frame resumes without a new request.

Source files
------------

// File: rtl/game_frame_tx.sv
// Host readout link transmitter: snapshots game state at launch and sends it
// word by word over a tagged four-phase valid/ack handshake.
module game_frame_tx #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_new_game,
  input  logic       result_valid,
  input  logic       hit,
  input  logic [4:0] target_x,
  input  logic [4:0] target_y,
  input  logic [4:0] x_pos,
  input  logic [2:0] aim_pos,
  input  logic [4:0] tc_pos,
  input  logic       host_ack,
  output logic [4:0] tx_data,
  output logic [2:0] tx_tag,
  output logic       tx_valid,
  output logic       game_go,
  output logic       busy,
  output logic       timeout_err
);
  typedef enum logic [1:0] {IDLE, PRESENT, RELEASE, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t          state;
  logic            ack_q, ack_s;
  logic            pend_start, pend_result, is_round;
  logic [3:0][4:0] words;
  logic [1:0]      idx, idx_nx;
  logic [7:0]      cnt;
  logic            req_s, req_r, launch_s, launch_r, last_word, tmo;
  logic [2:0]      tag_nx;
  logic [4:0]      status;

  always_comb begin
    req_s     = pend_start | start_new_game;
    req_r     = pend_result | result_valid;
    launch_s  = (state == IDLE) && req_s;
    launch_r  = (state == IDLE) && !req_s && req_r;
    last_word = idx == (is_round ? 2'd2 : 2'd1);
    idx_nx    = idx + 2'd1;
    tag_nx    = {1'b0, idx_nx} + (is_round ? 3'd1 : 3'd4);
    status    = {aim_pos, 1'b0, hit};
    tmo       = cnt == CNT_LAST;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ack_q       <= 1'b0;
      ack_s       <= 1'b0;
      pend_start  <= 1'b0;
      pend_result <= 1'b0;
      is_round    <= 1'b0;
      words       <= '0;
      idx         <= '0;
      cnt         <= '0;
      tx_data     <= '0;
      tx_tag      <= '0;
      tx_valid    <= 1'b0;
      game_go     <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      ack_q       <= host_ack;
      ack_s       <= ack_q;
      game_go     <= 1'b0;
      // Requests collapse into one flag each; a flag drops only when its frame launches.
      pend_start  <= req_s & ~launch_s;
      pend_result <= req_r & ~launch_r;
      case (state)
        IDLE: begin
          if (launch_s || launch_r) begin
            state       <= PRESENT;
            is_round    <= launch_s;
            words       <= launch_s ? {5'd0, x_pos, target_y, target_x}
                                    : {5'd0, x_pos, tc_pos, status};
            idx         <= '0;
            cnt         <= '0;
            busy        <= 1'b1;
            timeout_err <= 1'b0;
            tx_valid    <= 1'b1;
            tx_tag      <= launch_s ? 3'd1 : 3'd4;
            tx_data     <= launch_s ? target_x : status;
          end
        end
        PRESENT: begin
          if (ack_s) begin
            state    <= RELEASE;
            tx_valid <= 1'b0;
            cnt      <= '0;
          end else if (tmo) begin
            state       <= IDLE;
            tx_valid    <= 1'b0;
            tx_tag      <= '0;
            tx_data     <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RELEASE: begin
          if (!ack_s) begin
            if (last_word) begin
              state   <= DONE;
              game_go <= is_round;
              tx_tag  <= '0;
              tx_data <= '0;
            end else begin
              state    <= PRESENT;
              idx      <= idx_nx;
              cnt      <= '0;
              tx_valid <= 1'b1;
              tx_tag   <= tag_nx;
              tx_data  <= words[idx_nx];
            end
          end else if (tmo) begin
            state       <= IDLE;
            tx_tag      <= '0;
            tx_data     <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_game_frame_tx.sv
// Bench for game_frame_tx: frame-level reference model, host BFM with latency
// checks, directed scenarios with literal expectations, then random traffic.
module tb_game_frame_tx;
  localparam int TO = 10;

  logic       clk = 1'b0;
  logic       rst_n, start_new_game, result_valid, hit, host_ack;
  logic [4:0] target_x, target_y, x_pos, tc_pos;
  logic [2:0] aim_pos;
  logic [4:0] tx_data;
  logic [2:0] tx_tag;
  logic       tx_valid, game_go, busy, timeout_err;

  game_frame_tx #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start_new_game(start_new_game),
    .result_valid(result_valid), .hit(hit), .target_x(target_x),
    .target_y(target_y), .x_pos(x_pos), .aim_pos(aim_pos), .tc_pos(tc_pos),
    .host_ack(host_ack), .tx_data(tx_data), .tx_tag(tx_tag),
    .tx_valid(tx_valid), .game_go(game_go), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int nerr = 0, nchk = 0;
  int hmode = 0;   // 0 responsive host, 1 never acks, 2 driven by main
  int hdly  = -1;  // fixed ack delay, or random when negative
  int gocnt = 0;
  int log_tag[$], log_dat[$];

  // frame-level model state
  bit m_ps, m_pr, m_round;
  int m_idx, m_n;
  int exp_tag[3], exp_dat[3];

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    nchk++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: every cycle against the frame model.
  initial begin
    bit s_start, s_res, s_rst, s_hit, live_s, live_r;
    logic [4:0] s_tx, s_ty, s_xp, s_tc;
    logic [2:0] s_aim;
    bit p_busy, p_valid, p_go;
    logic [2:0] p_tag;
    logic [4:0] p_dat;
    p_busy = 0; p_valid = 0; p_go = 0; p_tag = 0; p_dat = 0;
    m_ps = 0; m_pr = 0; m_idx = 0; m_n = 0; m_round = 0;
    forever begin
      @(posedge clk);
      s_start = start_new_game; s_res = result_valid; s_rst = rst_n;
      s_tx = target_x; s_ty = target_y; s_xp = x_pos; s_tc = tc_pos;
      s_aim = aim_pos; s_hit = hit;
      #1;
      if (!s_rst) begin
        chk({tx_data, tx_tag, tx_valid, game_go, busy, timeout_err} == 0,
            "reset_outputs", {tx_data, tx_tag, tx_valid, game_go, busy, timeout_err}, 0);
        m_ps = 0; m_pr = 0; m_idx = 0; m_n = 0;
        p_busy = 0; p_valid = 0; p_go = 0; p_tag = 0; p_dat = 0;
        continue;
      end
      live_s = m_ps | s_start;
      live_r = m_pr | s_res;
      if (!p_busy) begin
        chk(busy == (live_s | live_r), "launch", busy, live_s | live_r);
        if (busy) begin
          m_round = live_s;
          m_idx = 0;
          if (live_s) begin
            m_n = 3;
            exp_tag = '{1, 2, 3};
            exp_dat = '{int'(s_tx), int'(s_ty), int'(s_xp)};
            live_s = 0;
          end else begin
            m_n = 2;
            exp_tag = '{4, 5, 0};
            exp_dat = '{int'(s_aim) * 4 + int'(s_hit), int'(s_tc), 0};
            live_r = 0;
          end
          chk(timeout_err == 0, "err_clear_on_launch", timeout_err, 0);
        end
      end
      m_ps = live_s;
      m_pr = live_r;
      if (game_go) gocnt++;
      chk(!(game_go && p_go), "go_single_pulse", game_go, 0);
      if (busy) begin
        if (tx_valid && !p_valid) begin
          log_tag.push_back(int'(tx_tag));
          log_dat.push_back(int'(tx_data));
          if (m_idx < m_n)
            chk(tx_tag == exp_tag[m_idx] && tx_data == exp_dat[m_idx], "word",
                int'(tx_tag) * 32 + int'(tx_data), exp_tag[m_idx] * 32 + exp_dat[m_idx]);
          else
            chk(0, "extra_word", int'(tx_tag) * 32 + int'(tx_data), 0);
          m_idx++;
        end else if (tx_valid) begin
          chk(tx_tag == p_tag && tx_data == p_dat, "word_stable",
              int'(tx_tag) * 32 + int'(tx_data), int'(p_tag) * 32 + int'(p_dat));
        end
        if (game_go)
          chk(m_round && m_idx == m_n && !tx_valid, "go_when_done", m_idx, m_n);
      end else begin
        chk({tx_valid, tx_tag, tx_data, game_go} == 0, "idle_outputs",
            {tx_valid, tx_tag, tx_data, game_go}, 0);
        if (p_busy) begin
          chk(timeout_err == (m_idx != m_n), "err_flag", timeout_err, m_idx != m_n);
          if (m_idx == m_n) chk(p_go == m_round, "go_on_done", p_go, m_round);
        end
      end
      p_busy = busy; p_valid = tx_valid; p_go = game_go; p_tag = tx_tag; p_dat = tx_data;
    end
  end

  // Host BFM with handshake latency checks.
  initial begin
    int d;
    bit remain;
    host_ack = 0;
    forever begin
      @(negedge clk);
      if (hmode == 0 && tx_valid && rst_n) begin
        d = (hdly < 0) ? int'($urandom_range(0, 4)) : hdly;
        repeat (d) @(negedge clk);
        host_ack = 1;
        @(posedge clk); @(posedge clk); #2;
        chk(tx_valid == 1, "ack_hold", tx_valid, 1);
        @(posedge clk); #2;
        chk(tx_valid == 0, "ack_drop", tx_valid, 0);
        d = (hdly < 0) ? int'($urandom_range(0, 4)) : hdly;
        @(negedge clk);
        repeat (d) @(negedge clk);
        host_ack = 0;
        @(posedge clk); @(posedge clk); #2;
        chk(tx_valid == 0, "release_hold", tx_valid, 0);
        remain = m_idx < m_n;
        @(posedge clk); #2;
        chk(tx_valid == remain, "release_next", tx_valid, remain);
        chk(busy == 1, "release_busy", busy, 1);
      end
    end
  end

  task automatic pulse(input bit s, input bit r);
    @(negedge clk);
    start_new_game = s; result_valid = r;
    @(negedge clk);
    start_new_game = 0; result_valid = 0;
  endtask

  task automatic wait_valid(input bit lvl, input string nm);
    int n = 0;
    while (tx_valid !== lvl && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    chk(tx_valid === lvl, nm, tx_valid, lvl);
  endtask

  task automatic wait_quiet(input string nm);
    int n = 0;
    while ((busy || m_ps || m_pr) && n < 3000) begin
      @(posedge clk); #2;
      n++;
    end
    chk(!busy && !m_ps && !m_pr, nm, busy, 0);
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic chk_word(input int i, input int tag, input int dat);
    if (i < log_tag.size())
      chk(log_tag[i] == tag && log_dat[i] == dat, "literal_word",
          log_tag[i] * 32 + log_dat[i], tag * 32 + dat);
    else
      chk(0, "literal_word_missing", log_tag.size(), i + 1);
  endtask

  task automatic clear_log();
    log_tag.delete(); log_dat.delete(); gocnt = 0;
  endtask

  initial begin
    int n, g;
    rst_n = 0; start_new_game = 0; result_valid = 0; hit = 0;
    target_x = 0; target_y = 0; x_pos = 0; tc_pos = 0; aim_pos = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Round frame, host acking after 3 cycles
    hdly = 3; clear_log();
    target_x = 7; target_y = 19; x_pos = 3;
    pulse(1, 0);
    wait_quiet("round_done");
    chk(log_tag.size() == 3, "round_len", log_tag.size(), 3);
    chk_word(0, 1, 7); chk_word(1, 2, 19); chk_word(2, 3, 3);
    chk(gocnt == 1, "round_go", gocnt, 1);
    chk(busy == 0, "round_busy", busy, 0);

    // Result frame
    clear_log();
    hit = 1; aim_pos = 5; tc_pos = 12;
    pulse(0, 1);
    wait_quiet("result_done");
    chk_word(0, 4, 5'b10101); chk_word(1, 5, 12);
    chk(gocnt == 0, "result_no_go", gocnt, 0);

    // Both requests together; result data changed mid round
    clear_log();
    target_x = 1; target_y = 2; x_pos = 4;
    pulse(1, 1);
    aim_pos = 2; hit = 0; tc_pos = 9;
    wait_quiet("both_done");
    chk(log_tag.size() == 5, "both_len", log_tag.size(), 5);
    chk_word(0, 1, 1); chk_word(2, 3, 4); chk_word(3, 4, 8); chk_word(4, 5, 9);
    chk(gocnt == 1, "both_go", gocnt, 1);

    // Snapshot at launch
    clear_log();
    target_x = 11;
    pulse(1, 0);
    target_x = 30;
    wait_quiet("snap_done");
    chk_word(0, 1, 11);

    // Timeout with a silent host
    hmode = 1; clear_log();
    pulse(1, 0);
    n = 0;
    while (tx_valid && n < 50) begin
      n++;
      @(posedge clk); #2;
    end
    chk(n == TO, "timeout_cycles", n, TO);
    chk(timeout_err == 1, "timeout_err_set", timeout_err, 1);
    chk(busy == 0, "timeout_busy", busy, 0);
    chk(gocnt == 0, "timeout_no_go", gocnt, 0);
    hmode = 0; hdly = 1;
    @(negedge clk);
    pulse(0, 1);
    chk(timeout_err == 0, "timeout_err_cleared", timeout_err, 0);
    wait_quiet("after_timeout_done");
    chk(log_tag.size() == 3, "after_timeout_len", log_tag.size(), 3);

    // Reset during release of the second word
    hmode = 2; clear_log();
    pulse(1, 0);
    @(negedge clk) host_ack = 1;
    wait_valid(0, "rst_rel1");
    @(negedge clk) host_ack = 0;
    wait_valid(1, "rst_word2");
    @(negedge clk) host_ack = 1;
    wait_valid(0, "rst_rel2");
    @(negedge clk) rst_n = 0;
    @(posedge clk); #2;
    chk({tx_valid, tx_tag, tx_data, busy, game_go, timeout_err} == 0, "rst_mid_frame",
        {tx_valid, tx_tag, tx_data, busy, game_go, timeout_err}, 0);
    @(negedge clk) begin rst_n = 1; host_ack = 0; end
    g = log_tag.size();
    repeat (20) @(posedge clk);
    #2;
    chk(busy == 0, "no_resume", busy, 0);
    chk(log_tag.size() == g, "no_resume_words", log_tag.size(), g);
    chk(gocnt == 0, "rst_no_go", gocnt, 0);

    // Random traffic
    hmode = 0; hdly = -1; clear_log();
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      start_new_game = ($urandom_range(0, 15) == 0);
      result_valid   = ($urandom_range(0, 15) == 0);
      target_x = 5'($urandom); target_y = 5'($urandom); x_pos = 5'($urandom);
      tc_pos = 5'($urandom); aim_pos = 3'($urandom); hit = 1'($urandom);
    end
    @(negedge clk);
    start_new_game = 0; result_valid = 0;
    wait_quiet("random_drain");
    chk(log_tag.size() > 20, "random_activity", log_tag.size(), 21);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
